// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states, port IDs, lock counter sizing.
// Also supplies the default for the WORD_WIDTH macro used as the data/address width.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    localparam logic ARB_P0 = 1'b0;
    localparam logic ARB_P1 = 1'b1;

    // $clog2(1) is 0, so keep at least one bit to leave the counter declarable.
    function automatic int lock_cnt_width(input int max_lock);
        return (max_lock > 1) ? $clog2(max_lock) : 1;
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection for dmem_arbiter.
// DMEM_ARB_RR_EN selects round-robin tie-breaking; fixed priority (port 0) otherwise.
module dmem_arb_pick
    import dmem_arbiter_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_locked,
    input  logic i_owner,
    input  logic i_last_owner,
    output logic o_valid,
    output logic o_winner,
    output logic o_release
);

    logic w_owner_req;
    logic w_tie_winner;

    assign w_owner_req = (i_owner == ARB_P1) ? i_req1 : i_req0;
    assign o_release   = i_locked & ~w_owner_req;

`ifdef DMEM_ARB_RR_EN
    assign w_tie_winner = ~i_last_owner;
`else
    logic w_unused_last_owner;
    assign w_unused_last_owner = i_last_owner;
    assign w_tie_winner        = ARB_P0;
`endif

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        o_valid  = 1'b0;
        o_winner = ARB_P0;
        if (i_locked && w_owner_req) begin
            o_valid  = 1'b1;
            o_winner = i_owner;
        end else if (i_req0 && i_req1) begin
            o_valid  = 1'b1;
            o_winner = w_tie_winner;
        end else if (i_req0) begin
            o_valid  = 1'b1;
            o_winner = ARB_P0;
        end else if (i_req1) begin
            o_valid  = 1'b1;
            o_winner = ARB_P1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing a single-ported data memory: one latched command, one access, one ack.
// Tie-break policy chosen by DMEM_ARB_RR_EN inside dmem_arb_pick; bounded locking for atomic runs.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int W        = `WORD_WIDTH,
    parameter int MAX_LOCK = 8
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic         req1,
    input  logic         we0,
    input  logic         we1,
    input  logic [W-1:0] addr0,
    input  logic [W-1:0] addr1,
    input  logic [W-1:0] wdata0,
    input  logic [W-1:0] wdata1,
    input  logic         lock0,
    input  logic         lock1,
    output logic         ack0,
    output logic         ack1,
    output logic [W-1:0] rdata0,
    output logic [W-1:0] rdata1,
    output logic         mem_read_en,
    output logic [W-1:0] mem_read_addr,
    input  logic [W-1:0] mem_read_data,
    output logic         mem_write_en,
    output logic [W-1:0] mem_write_addr,
    output logic [W-1:0] mem_write_data,
    output logic         busy
);

    localparam int              LOCK_W    = lock_cnt_width(MAX_LOCK);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(MAX_LOCK - 1);

    arb_state_t          r_state;
    logic                r_owner;
    logic                r_we;
    logic                r_locked;
    logic [LOCK_W-1:0]   r_lock_cnt;
    logic                r_last_owner;

    logic                w_grant;
    logic                w_winner;
    logic                w_release;
    logic                w_win_we;
    logic                w_win_lock;
    logic [W-1:0]        w_win_addr;
    logic [W-1:0]        w_win_wdata;
    logic [LOCK_W-1:0]   w_cnt_base;
    logic                w_keep_lock;

    dmem_arb_pick u_pick (
        .i_req0       (req0),
        .i_req1       (req1),
        .i_locked     (r_locked),
        .i_owner      (r_owner),
        .i_last_owner (r_last_owner),
        .o_valid      (w_grant),
        .o_winner     (w_winner),
        .o_release    (w_release)
    );

    assign w_win_we    = (w_winner == ARB_P1) ? we1    : we0;
    assign w_win_lock  = (w_winner == ARB_P1) ? lock1  : lock0;
    assign w_win_addr  = (w_winner == ARB_P1) ? addr1  : addr0;
    assign w_win_wdata = (w_winner == ARB_P1) ? wdata1 : wdata0;

    // A released run must not leak its count into the grant made in the same cycle.
    assign w_cnt_base  = w_release ? '0 : r_lock_cnt;
    assign w_keep_lock = w_win_lock && (w_cnt_base < LOCK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ARB_IDLE;
            r_owner        <= ARB_P0;
            r_we           <= 1'b0;
            r_locked       <= 1'b0;
            r_lock_cnt     <= '0;
            r_last_owner   <= ARB_P1;
            ack0           <= 1'b0;
            ack1           <= 1'b0;
            rdata0         <= '0;
            rdata1         <= '0;
            mem_read_en    <= 1'b0;
            mem_read_addr  <= '0;
            mem_write_en   <= 1'b0;
            mem_write_addr <= '0;
            mem_write_data <= '0;
            busy           <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            case (r_state)
                ARB_IDLE: begin
                    if (w_release) begin
                        r_locked   <= 1'b0;
                        r_lock_cnt <= '0;
                    end
                    if (w_grant) begin
                        r_owner      <= w_winner;
                        r_we         <= w_win_we;
                        r_last_owner <= w_winner;
                        if (w_keep_lock) begin
                            r_locked   <= 1'b1;
                            r_lock_cnt <= w_cnt_base + LOCK_W'(1);
                        end else begin
                            r_locked   <= 1'b0;
                            r_lock_cnt <= '0;
                        end
                        mem_read_en  <= ~w_win_we;
                        mem_write_en <= w_win_we;
                        if (w_win_we) begin
                            mem_write_addr <= w_win_addr;
                            mem_write_data <= w_win_wdata;
                        end else begin
                            mem_read_addr  <= w_win_addr;
                        end
                        busy    <= 1'b1;
                        r_state <= ARB_ACCESS;
                    end
                end
                ARB_ACCESS: begin
                    mem_read_en  <= 1'b0;
                    mem_write_en <= 1'b0;
                    if (!r_we) begin
                        if (r_owner == ARB_P1) rdata1 <= mem_read_data;
                        else                   rdata0 <= mem_read_data;
                    end
                    ack0    <= (r_owner == ARB_P0);
                    ack1    <= (r_owner == ARB_P1);
                    r_state <= ARB_RESP;
                end
                ARB_RESP: begin
                    ack0    <= 1'b0;
                    ack1    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= ARB_IDLE;
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural 64-word memory.
// Tie-break expectations follow DMEM_ARB_RR_EN when it is defined for the build.
module tb_dmem_arbiter;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         req0, req1, we0, we1, lock0, lock1;
    logic [W-1:0] addr0, addr1, wdata0, wdata1;
    logic         ack0, ack1;
    logic [W-1:0] rdata0, rdata1;
    logic         mem_read_en, mem_write_en;
    logic [W-1:0] mem_read_addr, mem_read_data, mem_write_addr, mem_write_data;
    logic         busy;

    logic [W-1:0] mem [0:63];
    int           n_cmp     = 0;
    int           n_mis     = 0;
    int           n_both_en = 0;
    int           grants[$];
    int           grant_cyc[$];

    dmem_arbiter #(.W(W), .MAX_LOCK(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req0           (req0),
        .req1           (req1),
        .we0            (we0),
        .we1            (we1),
        .addr0          (addr0),
        .addr1          (addr1),
        .wdata0         (wdata0),
        .wdata1         (wdata1),
        .lock0          (lock0),
        .lock1          (lock1),
        .ack0           (ack0),
        .ack1           (ack1),
        .rdata0         (rdata0),
        .rdata1         (rdata1),
        .mem_read_en    (mem_read_en),
        .mem_read_addr  (mem_read_addr),
        .mem_read_data  (mem_read_data),
        .mem_write_en   (mem_write_en),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_read_addr[7:2]];

    always @(posedge clk) begin
        if (mem_write_en) mem[mem_write_addr[7:2]] <= mem_write_data;
        if (mem_read_en && mem_write_en) n_both_en <= n_both_en + 1;
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_port(input bit p, input bit rq, input bit we, input logic [W-1:0] a,
                              input logic [W-1:0] d, input bit lk);
        if (p) begin
            req1 = rq; we1 = we; addr1 = a; wdata1 = d; lock1 = lk;
        end else begin
            req0 = rq; we0 = we; addr0 = a; wdata0 = d; lock0 = lk;
        end
    endtask

    task automatic apply_reset();
        drive_port(0, 0, 0, '0, '0, 0);
        drive_port(1, 0, 0, '0, '0, 0);
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // One access on one port; returns the read data seen with ack and edges until ack.
    task automatic single_access(input bit p, input bit we, input logic [W-1:0] a,
                                 input logic [W-1:0] d, output logic [W-1:0] rd, output int lat);
        bit got = 0;
        lat = 0;
        rd  = '0;
        drive_port(p, 1, we, a, d, 0);
        for (int c = 1; c <= 20 && !got; c++) begin
            tick();
            if ((p ? ack1 : ack0) === 1'b1) begin
                got = 1;
                lat = c;
                rd  = p ? rdata1 : rdata0;
            end
        end
        drive_port(p, 0, 0, '0, '0, 0);
        if (!got) check("ack_timeout", 0, 1);
        tick();
    endtask

    // Both ports issue reads; each drops req in the ack cycle of its last access.
    task automatic run_engine(input int cnt0, input int cnt1, input bit lk1, input int start0,
                              input int budget);
        int left0 = cnt0;
        int left1 = cnt1;
        grants.delete();
        grant_cyc.delete();
        if (left1 > 0) drive_port(1, 1, 0, 32'h10, '0, lk1);
        if (left0 > 0 && start0 == 0) drive_port(0, 1, 0, 32'h14, '0, 0);
        for (int c = 1; c <= budget && (left0 > 0 || left1 > 0); c++) begin
            tick();
            if (ack0 === 1'b1) begin
                grants.push_back(0);
                grant_cyc.push_back(c);
                left0--;
                if (left0 == 0) drive_port(0, 0, 0, '0, '0, 0);
            end
            if (ack1 === 1'b1) begin
                grants.push_back(1);
                grant_cyc.push_back(c);
                left1--;
                if (left1 == 0) drive_port(1, 0, 0, '0, '0, 0);
            end
            if (c == start0 && left0 > 0) drive_port(0, 1, 0, 32'h14, '0, 0);
        end
        drive_port(0, 0, 0, '0, '0, 0);
        drive_port(1, 0, 0, '0, '0, 0);
        if (left0 > 0 || left1 > 0) check("engine_timeout", left0 + left1, 0);
        tick();
    endtask

    task automatic check_grants(input string tag, input int exp[$]);
        int n;
        check({tag, "_count"}, grants.size(), exp.size());
        n = (grants.size() < exp.size()) ? grants.size() : exp.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_g%0d", tag, i), grants[i], exp[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rd;
        int           lat;
        int           exp_g[$];

        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
        mem[4] = 32'hDEAD_BEEF;
        drive_port(0, 0, 0, '0, '0, 0);
        drive_port(1, 0, 0, '0, '0, 0);
        rst_n = 1'b0;

        #12;
        check("rst_ctrl", {ack0, ack1, mem_read_en, mem_write_en, busy}, 0);
        check("rst_rdata0", rdata0, 0);
        check("rst_rdata1", rdata1, 0);
        check("rst_maddr", mem_read_addr | mem_write_addr | mem_write_data, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single read, cycle by cycle
        drive_port(0, 1, 0, 32'h10, '0, 0);
        tick();
        check("rd_en_c1", mem_read_en, 1);
        check("rd_addr_c1", mem_read_addr, 32'h10);
        check("wr_en_c1", mem_write_en, 0);
        check("busy_c1", busy, 1);
        check("ack0_c1", ack0, 0);
        tick();
        check("ack0_c2", ack0, 1);
        check("ack1_c2", ack1, 0);
        check("rdata0_c2", rdata0, 32'hDEAD_BEEF);
        check("rd_en_c2", mem_read_en, 0);
        drive_port(0, 0, 0, '0, '0, 0);
        tick();
        check("ack0_c3", ack0, 0);
        check("busy_c3", busy, 0);

        // Write then read on port 1
        drive_port(1, 1, 1, 32'h20, 32'h1234_5678, 0);
        tick();
        check("wr_en_c1", mem_write_en, 1);
        check("rd_en_wr_c1", mem_read_en, 0);
        check("wr_addr_c1", mem_write_addr, 32'h20);
        check("wr_data_c1", mem_write_data, 32'h1234_5678);
        tick();
        check("ack1_wr", ack1, 1);
        check("rdata1_wr_hold", rdata1, 0);
        drive_port(1, 0, 0, '0, '0, 0);
        tick();
        check("mem_written", mem[8], 32'h1234_5678);
        single_access(1, 0, 32'h20, '0, rd, lat);
        check("wr_rd_data", rd, 32'h1234_5678);
        check("wr_rd_lat", lat, 2);
        check("rdata0_untouched", rdata0, 32'hDEAD_BEEF);
        single_access(0, 1, 32'h24, 32'hCAFE_F00D, rd, lat);
        check("wr_keeps_rdata0", rd, 32'hDEAD_BEEF);

        // Low address bits pass through to the memory unchanged
        drive_port(0, 1, 0, 32'h13, '0, 0);
        tick();
        check("addr_lsb_pass", mem_read_addr, 32'h13);
        tick();
        check("addr_lsb_data", rdata0, 32'hDEAD_BEEF);
        drive_port(0, 0, 0, '0, '0, 0);
        tick();

        // Tie: both raised together and kept high
        apply_reset();
        run_engine(3, 2, 0, 0, 100);
`ifdef DMEM_ARB_RR_EN
        exp_g = '{0, 1, 0, 1, 0};
`else
        exp_g = '{0, 0, 0, 1, 1};
`endif
        check_grants("tie", exp_g);
        if (grant_cyc.size() >= 2) check("tie_period", grant_cyc[1] - grant_cyc[0], 3);

        // Lock bound: port 1 locked for 12 accesses, port 0 pending from the first ACCESS
        apply_reset();
        run_engine(1, 12, 1, 1, 200);
        exp_g = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1};
        check_grants("lock_bound", exp_g);

        // Lock release: owner drops req in IDLE, port 0 granted the same cycle
        apply_reset();
        run_engine(1, 2, 1, 1, 100);
        exp_g = '{1, 1, 0};
        check_grants("lock_rel", exp_g);
        if (grant_cyc.size() >= 3) check("lock_rel_gap", grant_cyc[2] - grant_cyc[1], 3);

        // Reset asserted in ACCESS
        apply_reset();
        drive_port(0, 1, 0, 32'h10, '0, 0);
        tick();
        check("rst_acc_pre", mem_read_en, 1);
        rst_n = 1'b0;
        #1;
        check("rst_acc_ctrl", {ack0, ack1, mem_read_en, mem_write_en, busy}, 0);
        check("rst_acc_addr", mem_read_addr, 0);
        check("rst_acc_rdata0", rdata0, 0);
        drive_port(0, 0, 0, '0, '0, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_acc_no_ack", {ack0, busy}, 0);
        single_access(0, 0, 32'h10, '0, rd, lat);
        check("rst_acc_after_data", rd, 32'hDEAD_BEEF);
        check("rst_acc_after_lat", lat, 2);

        check("enables_exclusive", n_both_en, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single-ported simulation data memory between the CPU MEM stage (port 0) and a debug/DMA requester (port 1). It sits between both requesters and the data memory's read/write port pair. It latches one request at a time, drives exactly one memory access, and returns a registered acknowledge and read data to the winner. Optional bounded bus locking lets a requester issue atomic multi-word sequences.

## Interface
Parameters:
- W, `WORD_WIDTH (32): data and address width
- MAX_LOCK, 8: maximum consecutive grants one locked owner may hold (≥1)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req0 / req1  in  1  request; held with command stable until matching ack
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  W  byte address, word-aligned
- wdata0 / wdata1  in  W  write data
- lock0 / lock1  in  1  request to keep ownership for the next access
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  W  read data, valid while ack is high
- mem_read_en  out  1  to memory read_en
- mem_read_addr  out  W  to memory read_addr
- mem_read_data  in  W  from memory read_data (combinational)
- mem_write_en  out  1  to memory write_en
- mem_write_addr  out  W  to memory write_addr
- mem_write_data  out  W  to memory write_data
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: when a request is eligible, pick a winner. Latch owner, we, addr, wdata into command registers, then go to ACCESS. With no eligible request, stay in IDLE.
- Eligibility: if the locked flag is set, only the owner is eligible. If the owner's req is low in IDLE, clear locked and arbitrate normally in the same cycle.
- ACCESS: drive memory from the command registers.
  - Read: mem_read_en=1, mem_read_addr=addr.
  - Write: mem_write_en=1, mem_write_addr/mem_write_data from the command registers.
  - Capture mem_read_data into the owner's rdata. Go to RESP.
- RESP: ack_owner=1 for this cycle only, then go to IDLE.
- Lock counter: lock_cnt counts grants in the current locked run.
  - At grant, if lock_owner=1 and lock_cnt<MAX_LOCK−1: set locked and increment lock_cnt.
  - Otherwise: clear locked and set lock_cnt=0.
- A write does not return data. The owner's rdata keeps its previous value.
- addr[1:0] is passed through unchanged. The memory ignores it.

## Timing
- Reset values: all acks 0, rdata0/rdata1 0, mem_* enables 0, mem addresses and data 0, busy 0, state IDLE, locked 0, lock_cnt 0, last_owner 1.
- Reset asserted mid-access aborts the access immediately. No ack is issued.
- Latency: req seen at edge k → memory access during cycle k+1 → ack and rdata valid during cycle k+2.
- Throughput: one access per 3 cycles.
- The requester may drop req, or present its next command, during the ack cycle. The arbiter resamples it in the following IDLE cycle.
- Memory enables are high only in ACCESS, never both at once.
- Simultaneous req0/req1 with neither locked: resolve per Configuration.
- A request raised during ACCESS or RESP waits. Its command must stay stable.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin. On a tie, the port ≠ last_owner wins. last_owner updates at every grant.
- DMEM_ARB_RR_EN undefined: fixed priority. Port 0 always wins ties. last_owner is unused.
- Locking works identically in both modes.

## Structure
- Shared package/defines file holds:
  - state encodings (ARB_IDLE, ARB_ACCESS, ARB_RESP)
  - port IDs (ARB_P0, ARB_P1)
  - lock counter width, $clog2(MAX_LOCK)
- One sub-module, dmem_arb_pick: combinational winner selection from req, locked, owner, last_owner. It is the only place the macro is tested.

## Test plan
- Single read: mem[4]=0xDEADBEEF; req0 read addr 0x10 at edge 0 → mem_read_en in cycle 1, ack0 and rdata0=0xDEADBEEF in cycle 2.
- Write then read: port 1 writes 0x12345678 to 0x20, then port 1 reads 0x20 → second ack1 carries 0x12345678.
- Tie: req0 and req1 both raised together repeatedly → RR: grants alternate 0,1,0,1; fixed: port 0 wins while req0 stays high.
- Lock bound: MAX_LOCK=8; port 1 holds lock and req for 12 accesses while req0 is pending → port 1 gets 8 grants, then port 0 is granted.
- Lock release: port 1 locks, then drops req for one IDLE cycle while req0 is high → port 0 is granted in that same cycle.
- Reset in ACCESS: rst_n low during ACCESS → all outputs 0 immediately, no ack; after release, a new req0 completes normally.
